add_sub_serial_p: RTL and testbench

//  Parametrised digit-serial adder/subtractor; successor to the fixed 8-bit bit-serial adder.

---
 rtl/add_serial_pkg.sv | 19 +
 rtl/serial_digit_add.sv | 27 ++
 rtl/add_sub_serial_p.sv | 158 +++++++++++++++
 tb/tb_add_sub_serial_p.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_serial_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM state encoding,
// operation mode constants and a counter width helper.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Digit counter width: enough to count WIDTH/DIGIT steps, never below 1 bit.
  function automatic int cnt_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_add.sv
// Combinational DIGIT-bit adder slice. Besides the digit sum and carry-out it
// reports the carry into the slice's top bit, which the top uses for signed
// overflow on the final digit.
module serial_digit_add
  import add_serial_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] d,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] total;

  // Plain ripple sum; carry into the MSB is recovered as sum ^ a ^ b of that bit.
  always_comb begin
    total    = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    d        = total[DIGIT-1:0];
    cout     = total[DIGIT];
    c_msb_in = total[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
  end

endmodule

// File: rtl/add_sub_serial_p.sv
// Digit-serial adder/subtractor: takes two WIDTH-bit operands over a
// valid/ready handshake, processes DIGIT bits per clock and holds the result
// until the consumer accepts it.
// Optional feature macro: ADD_SERIAL_OVF_EN adds the signed-overflow output.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high; an output transfer happens on a rising edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, sum/cout/ovf do not change. in_ready is high only in IDLE,
// out_valid only in DONE.
module add_sub_serial_p
  import add_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef ADD_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state_o
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("add_sub_serial_p: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [DIGIT-1:0] dig;
  logic             dig_cout, dig_c_msb;
  logic [WIDTH-1:0] sum_shift;
`ifdef ADD_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`else
  logic             unused_c_msb;
  assign unused_c_msb = dig_c_msb;
`endif

  serial_digit_add #(.DIGIT(DIGIT)) u_slice (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .cin      (carry_q),
    .d        (dig),
    .cout     (dig_cout),
    .c_msb_in (dig_c_msb)
  );

  // New digits enter the result at the top so the LSB digit ends up at bit 0.
  if (DIGIT == WIDTH) begin : g_one_digit
    assign sum_shift = dig;
  end else begin : g_multi_digit
    assign sum_shift = {dig, sum_q[WIDTH-1:DIGIT]};
  end

  // Next-state and datapath updates; clr overrides every transition.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADD_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
            a_d     = a;
            b_d     = (sub == MODE_SUB) ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
            sum_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          sum_d   = sum_shift;
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          carry_d = dig_cout;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cout_d  = dig_cout;
`ifdef ADD_SERIAL_OVF_EN
            ovf_d   = dig_c_msb ^ dig_cout;
`endif
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADD_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
`ifdef ADD_SERIAL_OVF_EN
  assign ovf         = ovf_q;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add_sub_serial_p.sv
// Bench for add_sub_serial_p. Lane 0 (WIDTH=8, DIGIT=1) runs directed cases:
// reference sums, backpressure, clr abort and mid-RUN reset. Six further lanes
// (8/4 and 16 with DIGIT 1,2,4,8,16) run randomized operands with random
// out_ready. Drivers push expected results into per-lane queues; monitors pop
// and compare on every output transfer and check the accept-to-valid latency.
// Build with and without ADD_SERIAL_OVF_EN.
module tb_add_sub_serial_p;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;
  int   lanes_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count, used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference result from plain integer arithmetic: {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(input int w, input longint a, input longint b, input logic s);
    longint m, r, sa, sb, sr;
    logic c, v;
    m = longint'(1) << w;
    if (s) begin
      r = a - b;
      c = (a >= b);
    end else begin
      r = a + b;
      c = (r >= m);
    end
    if (r < 0) r = r + m;
    r  = r % m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = s ? sa - sb : sa + sb;
    v  = (sr >= m / 2) || (sr < -(m / 2));
    return {v, c, 32'(r)};
  endfunction

  function automatic int lane_w(input int g);
    return (g == 0) ? 8 : 16;
  endfunction

  function automatic int lane_d(input int g);
    case (g)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 4;
      4: return 8;
      default: return 16;
    endcase
  endfunction

  // ---------------- lane 0: WIDTH=8, DIGIT=1, directed ----------------
  logic       rst0_n, clr0, in_valid0, in_ready0, sub0, out_valid0, out_ready0, cout0;
  logic [7:0] a0, b0, sum0;
  logic [1:0] dbg0;
`ifdef ADD_SERIAL_OVF_EN
  logic       ovf0;
`endif
  logic [33:0] exp0_q[$];
  logic [33:0] e0;
  int          acc0;
  logic        prev_v0 = 1'b0;
  logic        rst_g_n;

  add_sub_serial_p #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst0_n),
    .clr        (clr0),
    .in_valid   (in_valid0),
    .in_ready   (in_ready0),
    .a          (a0),
    .b          (b0),
    .sub        (sub0),
    .out_valid  (out_valid0),
    .out_ready  (out_ready0),
    .sum        (sum0),
    .cout       (cout0),
`ifdef ADD_SERIAL_OVF_EN
    .ovf        (ovf0),
`endif
    .dbg_state_o(dbg0)
  );

  // Lane 0 monitor: latency on out_valid rise, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (out_valid0 && !prev_v0) chk("lane0 latency", cyc - acc0, 8);
    prev_v0 <= out_valid0;
    if (out_valid0 && out_ready0) begin
      if (exp0_q.size() == 0) begin
        chk("lane0 unexpected result", 1, 0);
      end else begin
        e0 = exp0_q.pop_front();
        chk("lane0 sum", sum0, e0[7:0]);
        chk("lane0 cout", cout0, e0[32]);
`ifdef ADD_SERIAL_OVF_EN
        chk("lane0 ovf", ovf0, e0[33]);
`endif
      end
    end
  end

  task automatic issue0(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input bit expect_res);
    int t;
    @(posedge clk); #1;
    in_valid0 = 1'b1; a0 = ta; b0 = tb; sub0 = ts;
    t = 0;
    @(negedge clk);
    while (!in_ready0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("lane0 accept", in_ready0, 1);
    if (expect_res) exp0_q.push_back(model(8, ta, tb, ts));
    acc0 = cyc + 1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic drain0();
    int t;
    t = 0;
    while (exp0_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("lane0 drain", exp0_q.size(), 0);
  endtask

  // ---------------- lanes 1..6: randomized ----------------
  for (genvar g = 0; g < 6; g++) begin : g_lane
    localparam int W = lane_w(g);
    localparam int D = lane_d(g);
    localparam int N = W / D;
    localparam int NOPS = 40;

    logic         clr_l = 1'b0;
    logic         in_valid, in_ready, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum, ra, rb;
    logic         rs;
    logic [1:0]   dbg;
`ifdef ADD_SERIAL_OVF_EN
    logic         ovf;
`endif
    logic [33:0]  exp_q[$];
    logic [33:0]  e;
    int           acc_cyc;
    logic         prev_v = 1'b0;

    add_sub_serial_p #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk        (clk),
      .rst_n      (rst_g_n),
      .clr        (clr_l),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .sub        (sub),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum        (sum),
      .cout       (cout),
`ifdef ADD_SERIAL_OVF_EN
      .ovf        (ovf),
`endif
      .dbg_state_o(dbg)
    );

    // Random consumer backpressure.
    initial begin
      out_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    // Driver: random operands, first op of the 8/4 lane is FF+01.
    initial begin
      int t;
      in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
      wait (rst_g_n === 1'b1);
      for (int k = 0; k < NOPS; k++) begin
        if (g == 0 && k == 0) begin
          ra = '1; rb = W'(1); rs = 1'b0;
        end else begin
          ra = W'($urandom);
          rb = W'($urandom);
          rs = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 5) == 0) ra = {1'b1, {(W-1){1'b0}}};
          if ($urandom_range(0, 5) == 0) rb = '1;
        end
        @(posedge clk); #1;
        in_valid = 1'b1; a = ra; b = rb; sub = rs;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
          @(negedge clk);
          t++;
        end
        chk($sformatf("lane%0d accept", g + 1), in_ready, 1);
        exp_q.push_back(model(W, ra, rb, rs));
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("lane%0d drain", g + 1), exp_q.size(), 0);
      lanes_done++;
    end

    // Monitor: latency on out_valid rise, scoreboard pop on each transfer.
    always @(negedge clk) begin
      if (out_valid && !prev_v) chk($sformatf("lane%0d latency", g + 1), cyc - acc_cyc, N);
      prev_v <= out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("lane%0d unexpected result", g + 1), 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("lane%0d sum", g + 1), sum, e[W-1:0]);
          chk($sformatf("lane%0d cout", g + 1), cout, e[32]);
`ifdef ADD_SERIAL_OVF_EN
          chk($sformatf("lane%0d ovf", g + 1), ovf, e[33]);
`endif
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main directed sequence ----------------
  initial begin
    logic [33:0] exp_bp;
    int          seen;
    int          t;
    rst0_n = 1'b0; rst_g_n = 1'b0;
    clr0 = 1'b0; in_valid0 = 1'b0; a0 = '0; b0 = '0; sub0 = 1'b0; out_ready0 = 1'b1;
    #12;
    chk("reset in_ready", in_ready0, 1);
    chk("reset out_valid", out_valid0, 0);
    chk("reset sum", sum0, 0);
    chk("reset cout", cout0, 0);
    chk("reset state", dbg0, 0);
`ifdef ADD_SERIAL_OVF_EN
    chk("reset ovf", ovf0, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b1; rst_g_n = 1'b1;

    // Reference additions/subtractions.
    issue0(8'h5A, 8'h33, 1'b0, 1'b1);
    drain0();
    issue0(8'h10, 8'h20, 1'b1, 1'b1);
    drain0();
    issue0(8'h80, 8'h01, 1'b1, 1'b1);
    drain0();

    // Backpressure: result held, in_valid ignored while in DONE.
    out_ready0 = 1'b0;
    issue0(8'hC0, 8'hA0, 1'b0, 1'b1);
    exp_bp = model(8, 8'hC0, 8'hA0, 1'b0);
    t = 0;
    while (!out_valid0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp out_valid", out_valid0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid0 = (i == 2); a0 = 8'h11; b0 = 8'h22;
      @(negedge clk);
      chk("bp hold sum", sum0, exp_bp[7:0]);
      chk("bp hold valid", out_valid0, 1);
      chk("bp in_ready low", in_ready0, 0);
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp back to idle", in_ready0, 1);
    chk("bp valid dropped", out_valid0, 0);
    chk("bp sum kept in idle", sum0, exp_bp[7:0]);

    // clr at RUN cycle 3: abort, result flags kept.
    issue0(8'h0F, 8'h0F, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    @(negedge clk);
    chk("clr in_ready", in_ready0, 1);
    chk("clr out_valid", out_valid0, 0);
    chk("clr cout kept", cout0, exp_bp[32]);
`ifdef ADD_SERIAL_OVF_EN
    chk("clr ovf kept", ovf0, exp_bp[33]);
`endif
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(out_valid0);
    end
    chk("clr no out_valid", seen, 0);

    // Asynchronous reset mid-RUN.
    issue0(8'h33, 8'h44, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst0_n = 1'b0;
    #1;
    chk("rst in_ready", in_ready0, 1);
    chk("rst out_valid", out_valid0, 0);
    chk("rst sum", sum0, 0);
    chk("rst cout", cout0, 0);
`ifdef ADD_SERIAL_OVF_EN
    chk("rst ovf", ovf0, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(out_valid0);
    end
    chk("rst no out_valid", seen, 0);
    issue0(8'h01, 8'h01, 1'b0, 1'b1);
    drain0();

    // Random ops on lane 0, back to back.
    for (int k = 0; k < 30; k++) begin
      issue0(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain0();

    t = 0;
    while (lanes_done < 6 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("lanes finished", lanes_done, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
